// File: rtl/unary_product_accumulator.sv
// Unary product accumulator: measures serial unary runs, sums them into a binary
// accumulator and hands the sum downstream on flush over a valid/ready register.
module unary_product_accumulator #(
  parameter int BIN_BITS = 4,
  parameter int ACC_BITS = 16,
  parameter int CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_unary,
  input  logic                flush,
  output logic [ACC_BITS-1:0] out_sum,
  output logic [CNT_BITS-1:0] out_count,
  output logic                out_sat,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam int U_BITS   = 1 << BIN_BITS;
  localparam int RUN_BITS = $clog2(U_BITS * U_BITS) + 1;
  localparam int SUM_W    = ((ACC_BITS > RUN_BITS) ? ACC_BITS : RUN_BITS) + 1;
  localparam logic [ACC_BITS-1:0] ACC_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [RUN_BITS-1:0] RUN_MAX = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t              state, state_next;
  logic [RUN_BITS-1:0] run, run_next;
  logic [ACC_BITS-1:0] acc, acc_next;
  logic [CNT_BITS-1:0] cnt, cnt_next;
  logic                sat, sat_next;
  logic                pending, pending_next;
  logic [ACC_BITS-1:0] out_sum_next;
  logic [CNT_BITS-1:0] out_count_next;
  logic                out_sat_next;
  logic                out_valid_next;

  logic                run_close;
  logic                mid_run;
  logic                out_free;
  logic                emit;
  logic [SUM_W-1:0]    sum_wide;
  logic                acc_ovf;
  logic [ACC_BITS-1:0] acc_closed;
  logic [CNT_BITS-1:0] cnt_closed;

  assign run_close  = (state == COUNT) && !in_unary;
  assign mid_run    = (state == COUNT) && in_unary;
  assign sum_wide   = SUM_W'(acc) + SUM_W'(run);
  assign acc_ovf    = sum_wide > SUM_W'(ACC_MAX);
  assign acc_closed = acc_ovf ? ACC_MAX : sum_wide[ACC_BITS-1:0];
  assign cnt_closed = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  // Output handshake: a result is transferred on any edge where out_valid and
  // out_ready are both high; while out_valid=1 and out_ready=0 the result holds
  // still. The register counts as free when empty or retiring on this edge, so a
  // new result may load in the same edge the old one leaves.
  assign out_free = !out_valid || out_ready;

  // A flush (fresh or pending) never splits an open run; it waits for the run to
  // close and then includes it.
  assign emit = (flush || pending) && !mid_run && out_free;

  assign busy = (state == COUNT) || pending;

  always_comb begin
    state_next     = state;
    run_next       = run;
    acc_next       = acc;
    cnt_next       = cnt;
    sat_next       = sat;
    pending_next   = pending;
    out_sum_next   = out_sum;
    out_count_next = out_count;
    out_sat_next   = out_sat;
    out_valid_next = out_valid && !out_ready;

    case (state)
      IDLE: begin
        if (in_unary) begin
          run_next   = RUN_BITS'(1);
          state_next = COUNT;
        end
      end
      COUNT: begin
        if (in_unary) begin
          if (run == RUN_MAX) begin
            sat_next = 1'b1;
          end else begin
            run_next = run + 1'b1;
          end
        end else begin
          acc_next   = acc_closed;
          cnt_next   = cnt_closed;
          sat_next   = sat || acc_ovf;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Emission snapshots the totals after any closing run, then restarts them.
    if (emit) begin
      out_sum_next   = acc_next;
      out_count_next = cnt_next;
      out_sat_next   = sat_next;
      out_valid_next = 1'b1;
      acc_next       = '0;
      cnt_next       = '0;
      sat_next       = 1'b0;
      pending_next   = 1'b0;
    end else if (flush) begin
      pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      run       <= '0;
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      pending   <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      run       <= run_next;
      acc       <= acc_next;
      cnt       <= cnt_next;
      sat       <= sat_next;
      pending   <= pending_next;
      out_sum   <= out_sum_next;
      out_count <= out_count_next;
      out_sat   <= out_sat_next;
      out_valid <= out_valid_next;
    end
  end

endmodule

// File: doc/unary_product_accumulator.md
Name: unary_product_accumulator

Overview:
- Downstream stage of the serial unary multiplier inside the unary shift MAC.
- Consumes the multiplier's serial unary product stream. Each product arrives as k consecutive 1 cycles followed by at least one 0 cycle.
- Measures each run length and adds it into a binary accumulator, forming the MAC sum.
- On a flush request, hands the binary sum to the next stage over a valid/ready handshake. It never stalls the serial stream.

Parameters:
- BIN_BITS, 4, operand width of the multiplier; one operand occupies U_BITS = 2^BIN_BITS unary bits.
- ACC_BITS, 16, accumulator and out_sum width.
- CNT_BITS, 8, width of the products-per-result counter.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_unary  input  1  serial unary product bit from the multiplier.
- flush  input  1  single-cycle request to emit the current sum and restart accumulation.
- out_sum  output  ACC_BITS  accumulated binary sum; valid while out_valid=1.
- out_count  output  CNT_BITS  number of products (runs) included in out_sum.
- out_sat  output  1  out_sum or a run count saturated during this accumulation.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result when out_valid & out_ready.
- busy  output  1  run currently open, or a flush is pending.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - run counter, accumulator, product counter, sat flag, flush_pending all 0; FSM to IDLE.
  - out_sum=0, out_count=0, out_sat=0, out_valid=0, busy=0.
  - Reset mid-run or mid-handshake discards everything; no partial result is emitted.
- Run FSM, states IDLE and COUNT:
  - IDLE, in_unary=1: run counter <= 1; go to COUNT.
  - COUNT, in_unary=1: run counter +1. The counter is 2*BIN_BITS+1 bits wide (max run U_BITS*U_BITS = 256 at default) and saturates at all-ones, setting sat.
  - COUNT, in_unary=0: run closes. At that edge, acc <= acc + run, product counter +1; go to IDLE.
- Latency: a run covering cycles t..t+k-1, closed by in_unary=0 at cycle t+k, is visible in the accumulator from cycle t+k+1.
- Zero-length runs (zero products) are not counted. out_count counts only nonzero products.
- Accumulator add saturates at 2^ACC_BITS-1 and sets sat. The product counter saturates at 2^CNT_BITS-1 without setting sat.
- Flush when the FSM is IDLE, or a run closes in the same cycle, and the output register is free:
  - Next edge: out_sum <= acc plus any run closing this cycle; out_count and out_sat are loaded the same way.
  - out_valid <= 1.
  - acc, product counter and sat cleared to 0.
- Flush during an open run (COUNT with in_unary=1):
  - Set flush_pending; busy=1.
  - Emit on the edge where the run closes, including that run.
- Output register occupied (out_valid=1 and out_ready=0 in the flush/emit cycle):
  - Emission is deferred; flush_pending held.
  - Emission occurs on the edge where the handshake completes. The new result loads in the same edge that retires the old one, so out_valid stays 1.
- Flush while flush_pending is already set is absorbed; at most one result per pending flush.
- Accumulation continues while out_valid=1: in_unary bits arriving during the wait are counted into the new accumulation. The serial input is never back-pressured.
- Handshake: out_valid drops on the edge after out_valid & out_ready unless a new emission loads the same edge. out_sum, out_count and out_sat are stable while out_valid=1 and out_ready=0.
- busy = (state==COUNT) | flush_pending.

Test Plan:
- Runs of 3, 5 and 7 ones, each followed by one 0, then flush in an idle cycle with out_ready=1 -> out_valid one cycle later with out_sum=15, out_count=3, out_sat=0; accumulator 0 afterwards.
- Flush asserted during the 4th cycle of a 6-cycle run -> busy=1 until the run closes; out_valid the cycle after the closing 0 with out_sum=6, out_count=1.
- out_ready=0 for 10 cycles after an emission (sum 9) while a 4-run arrives and a second flush is issued -> first result held stable at 9; after out_ready=1, the next result is out_sum=4, out_count=1 and out_valid stays high across the swap.
- Run of 256 ones with ACC_BITS=8 -> out_sum=255, out_sat=1; the following accumulation starts with out_sat=0.
- Flush with no runs since the last flush -> out_sum=0, out_count=0, out_valid pulses normally.
- reset_n low mid-run (5 ones seen), then a 2-run and flush -> out_sum=2, out_count=1; all outputs 0 during reset.
